// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv
// Purpose  : Execute-stage ALU with a multiplier and an iterative divider.
//            Logic, shift, add/sub, multiply and divide-by-zero results are
//            registered and appear one cycle after acceptance. A divide with
//            a non-zero divisor runs a radix-2 restoring divider for DATA_W
//            cycles. During that time o_ready stays low.
// Ports    : clk          rising-edge clock
//            i_rst_n      synchronous active-low reset
//            i_valid      operation request
//            i_op         opcode (0 OR .. 10 DIV, 11-15 illegal)
//            i_signed     signed interpretation for MUL/DIV
//            i_src_a      operand A
//            i_src_b      operand B
//            i_flush      drops the request in this cycle / aborts a divide
//            o_ready      request can be accepted this cycle
//            o_valid      one-cycle result strobe
//            o_lo, o_hi   result halves (held between strobes)
//            o_div_zero   divide-by-zero flag qualifying o_valid
// Revision : 1.0  initial release
// ============================================================================
module ex_muldiv #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [3:0]        i_op,
    input  logic              i_signed,
    input  logic [DATA_W-1:0] i_src_a,
    input  logic [DATA_W-1:0] i_src_b,
    input  logic              i_flush,
    output logic              o_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_lo,
    output logic [DATA_W-1:0] o_hi,
    output logic              o_div_zero
);

    localparam logic [3:0] c_OP_OR  = 4'd0;
    localparam logic [3:0] c_OP_AND = 4'd1;
    localparam logic [3:0] c_OP_NOR = 4'd2;
    localparam logic [3:0] c_OP_XOR = 4'd3;
    localparam logic [3:0] c_OP_SLL = 4'd4;
    localparam logic [3:0] c_OP_SRL = 4'd5;
    localparam logic [3:0] c_OP_SRA = 4'd6;
    localparam logic [3:0] c_OP_ADD = 4'd7;
    localparam logic [3:0] c_OP_SUB = 4'd8;
    localparam logic [3:0] c_OP_MUL = 4'd9;
    localparam logic [3:0] c_OP_DIV = 4'd10;

    localparam logic [DATA_W-1:0]  c_ONE      = DATA_W'(1);
    localparam logic [DATA_W-1:0]  c_ZERO     = '0;
    localparam logic [SHAMT_W-1:0] c_CNT_ONE  = SHAMT_W'(1);
    localparam logic [SHAMT_W-1:0] c_CNT_LAST = SHAMT_W'(DATA_W - 1);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_DIV_RUN = 1'b1
    } state_t;

    state_t              r_state;
    logic                r_valid;
    logic [DATA_W-1:0]   r_lo;
    logic [DATA_W-1:0]   r_hi;
    logic                r_div_zero;

    // Divider state: r_quo starts as |dividend| and shifts quotient bits in
    // from the right while the dividend bits shift out of the top.
    logic [DATA_W-1:0]   r_quo;
    logic [DATA_W-1:0]   r_rem;
    logic [DATA_W-1:0]   r_dvs;
    logic [SHAMT_W-1:0]  r_cnt;
    logic                r_neg_q;
    logic                r_neg_r;

    logic                w_accept;
    logic                w_start_div;
    logic [SHAMT_W-1:0]  w_shamt;
    logic [DATA_W-1:0]   w_sra;
    logic [2*DATA_W-1:0] w_a_ext;
    logic [2*DATA_W-1:0] w_b_ext;
    logic [2*DATA_W-1:0] w_prod;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [DATA_W-1:0]   w_mag_a;
    logic [DATA_W-1:0]   w_mag_b;
    logic [DATA_W:0]     w_rem_sh;
    logic [DATA_W:0]     w_diff;
    logic                w_qbit;
    logic [DATA_W-1:0]   w_rem_next;
    logic [DATA_W-1:0]   w_quo_next;
    logic [DATA_W-1:0]   w_q_fix;
    logic [DATA_W-1:0]   w_r_fix;
    logic [DATA_W-1:0]   w_lo;
    logic [DATA_W-1:0]   w_hi;
    logic                w_div_zero;

    assign o_ready    = (r_state == S_IDLE);
    assign o_valid    = r_valid;
    assign o_lo       = r_lo;
    assign o_hi       = r_hi;
    assign o_div_zero = r_div_zero;

    assign w_accept    = i_valid & o_ready & ~i_flush;
    assign w_start_div = (i_op == c_OP_DIV) && (i_src_b != c_ZERO);

    assign w_shamt = i_src_b[SHAMT_W-1:0];
    assign w_sra   = $signed(i_src_a) >>> w_shamt;

    // Extending both operands to 2*DATA_W lets one multiplier serve both
    // signednesses: the low 2*DATA_W bits of the product are exact.
    assign w_a_ext = i_signed ? {{DATA_W{i_src_a[DATA_W-1]}}, i_src_a}
                              : {{DATA_W{1'b0}}, i_src_a};
    assign w_b_ext = i_signed ? {{DATA_W{i_src_b[DATA_W-1]}}, i_src_b}
                              : {{DATA_W{1'b0}}, i_src_b};
    assign w_prod  = w_a_ext * w_b_ext;

    assign w_a_neg = i_signed & i_src_a[DATA_W-1];
    assign w_b_neg = i_signed & i_src_b[DATA_W-1];
    assign w_mag_a = w_a_neg ? (~i_src_a + c_ONE) : i_src_a;
    assign w_mag_b = w_b_neg ? (~i_src_b + c_ONE) : i_src_b;

    // One restoring step. The partial remainder is always below the divisor,
    // so the shifted value fits in DATA_W+1 bits. A cleared borrow means the
    // subtraction is kept.
    assign w_rem_sh   = {r_rem, r_quo[DATA_W-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_dvs};
    assign w_qbit     = ~w_diff[DATA_W];
    assign w_rem_next = w_qbit ? w_diff[DATA_W-1:0] : w_rem_sh[DATA_W-1:0];
    assign w_quo_next = {r_quo[DATA_W-2:0], w_qbit};

    // The quotient is truncated toward zero. The remainder follows the
    // dividend's sign. MIN / -1 yields magnitude 2^(DATA_W-1) with no
    // negation, which already reads back as MIN.
    assign w_q_fix = r_neg_q ? (~w_quo_next + c_ONE) : w_quo_next;
    assign w_r_fix = r_neg_r ? (~w_rem_next + c_ONE) : w_rem_next;

    // Single-cycle results. DIV with a non-zero divisor is handled by the FSM.
    always_comb begin
        w_lo       = c_ZERO;
        w_hi       = c_ZERO;
        w_div_zero = 1'b0;
        case (i_op)
            c_OP_OR:  w_lo = i_src_a | i_src_b;
            c_OP_AND: w_lo = i_src_a & i_src_b;
            c_OP_NOR: w_lo = ~(i_src_a | i_src_b);
            c_OP_XOR: w_lo = i_src_a ^ i_src_b;
            c_OP_SLL: w_lo = i_src_a << w_shamt;
            c_OP_SRL: w_lo = i_src_a >> w_shamt;
            c_OP_SRA: w_lo = w_sra;
            c_OP_ADD: w_lo = i_src_a + i_src_b;
            c_OP_SUB: w_lo = i_src_a - i_src_b;
            c_OP_MUL: begin
                w_lo = w_prod[DATA_W-1:0];
                w_hi = w_prod[2*DATA_W-1:DATA_W];
            end
            c_OP_DIV: begin
                w_lo       = '1;
                w_hi       = i_src_a;
                w_div_zero = 1'b1;
            end
            default: begin
                w_lo = c_ZERO;
                w_hi = c_ZERO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_valid    <= 1'b0;
            r_lo       <= c_ZERO;
            r_hi       <= c_ZERO;
            r_div_zero <= 1'b0;
            r_quo      <= c_ZERO;
            r_rem      <= c_ZERO;
            r_dvs      <= c_ZERO;
            r_cnt      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_start_div) begin
                            r_state <= S_DIV_RUN;
                            r_quo   <= w_mag_a;
                            r_rem   <= c_ZERO;
                            r_dvs   <= w_mag_b;
                            r_cnt   <= '0;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                        end else begin
                            r_valid    <= 1'b1;
                            r_lo       <= w_lo;
                            r_hi       <= w_hi;
                            r_div_zero <= w_div_zero;
                        end
                    end
                end
                S_DIV_RUN: begin
                    if (i_flush) begin
                        r_state <= S_IDLE;
                        r_quo   <= c_ZERO;
                        r_rem   <= c_ZERO;
                        r_dvs   <= c_ZERO;
                        r_cnt   <= '0;
                        r_neg_q <= 1'b0;
                        r_neg_r <= 1'b0;
                    end else begin
                        r_quo <= w_quo_next;
                        r_rem <= w_rem_next;
                        r_cnt <= r_cnt + c_CNT_ONE;
                        // The final step writes the sign-corrected result in
                        // the same edge so o_valid and o_ready rise together.
                        if (r_cnt == c_CNT_LAST) begin
                            r_state    <= S_IDLE;
                            r_valid    <= 1'b1;
                            r_lo       <= w_q_fix;
                            r_hi       <= w_r_fix;
                            r_div_zero <= 1'b0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv
// Purpose  : Self-checking bench for ex_muldiv (DATA_W = 32). Stimulus pushes
//            expected results into a scoreboard. A monitor compares every
//            o_valid strobe against it, including the arrival cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_ex_muldiv;

    localparam int W = 32;

    logic         clk;
    logic         i_rst_n;
    logic         i_valid;
    logic [3:0]   i_op;
    logic         i_signed;
    logic [W-1:0] i_src_a;
    logic [W-1:0] i_src_b;
    logic         i_flush;
    logic         o_ready;
    logic         o_valid;
    logic [W-1:0] o_lo;
    logic [W-1:0] o_hi;
    logic         o_div_zero;

    ex_muldiv #(.DATA_W(W)) dut (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .i_op       (i_op),
        .i_signed   (i_signed),
        .i_src_a    (i_src_a),
        .i_src_b    (i_src_b),
        .i_flush    (i_flush),
        .o_ready    (o_ready),
        .o_valid    (o_valid),
        .o_lo       (o_lo),
        .o_hi       (o_hi),
        .o_div_zero (o_div_zero)
    );

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dz;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: got o_valid=1 expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("lo", o_lo, e.lo);
                chk("hi", o_hi, e.hi);
                chk("div_zero", o_div_zero, e.dz);
                chk("valid_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // Reference model, written directly from the arithmetic definitions.
    task automatic model(input logic [3:0] op, input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b, output logic [W-1:0] lo,
                         output logic [W-1:0] hi, output logic dz, output int lat);
        longint       sa, sbv, q, r, p;
        logic [63:0]  up;
        int           sh;
        sh  = int'(b % 32);
        lo  = '0;
        hi  = '0;
        dz  = 1'b0;
        lat = 0;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        case (op)
            4'd0: lo = a | b;
            4'd1: lo = a & b;
            4'd2: lo = ~(a | b);
            4'd3: lo = a ^ b;
            4'd4: lo = a << sh;
            4'd5: lo = a >> sh;
            4'd6: begin
                p  = sa >>> sh;
                lo = p[31:0];
            end
            4'd7: lo = a + b;
            4'd8: lo = a - b;
            4'd9: begin
                if (s) begin
                    p  = sa * sbv;
                    lo = p[31:0];
                    hi = p[63:32];
                end else begin
                    up = {32'd0, a} * {32'd0, b};
                    lo = up[31:0];
                    hi = up[63:32];
                end
            end
            4'd10: begin
                if (b == 0) begin
                    lo = '1;
                    hi = a;
                    dz = 1'b1;
                end else begin
                    lat = 32;
                    if (s) begin
                        q  = sa / sbv;
                        r  = sa % sbv;
                        lo = q[31:0];
                        hi = r[31:0];
                    end else begin
                        lo = a / b;
                        hi = a % b;
                    end
                end
            end
            default: begin
                lo = '0;
                hi = '0;
            end
        endcase
    endtask

    // Present a request, hold it until accepted, optionally record expectation.
    task automatic issue(input logic [3:0] op, input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] elo,
                         input logic [W-1:0] ehi, input logic edz, input int lat,
                         input bit push);
        int   t;
        exp_t e;
        i_valid  = 1'b1;
        i_op     = op;
        i_signed = s;
        i_src_a  = a;
        i_src_b  = b;
        t = 0;
        while (!o_ready && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!o_ready) chk("ready_timeout", o_ready, 1);
        if (push) begin
            e.lo  = elo;
            e.hi  = ehi;
            e.dz  = edz;
            e.cyc = cyc + 1 + lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic issue_rand(input logic [3:0] op, input logic s,
                              input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] lo, hi;
        logic         dz;
        int           lat;
        model(op, s, a, b, lo, hi, dz, lat);
        issue(op, s, a, b, lo, hi, dz, lat, 1'b1);
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] corners [6];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'h7FFF_FFFF;
        corners[5] = 32'h0000_0007;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        int n;
        i_rst_n  = 1'b0;
        i_valid  = 1'b0;
        i_op     = '0;
        i_signed = 1'b0;
        i_src_a  = '0;
        i_src_b  = '0;
        i_flush  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        i_rst_n = 1'b1;

        chk("rst_valid", o_valid, 0);
        chk("rst_lo", o_lo, 0);
        chk("rst_hi", o_hi, 0);
        chk("rst_div_zero", o_div_zero, 0);
        chk("rst_ready", o_ready, 1);

        issue(4'd6, 1'b0, 32'h8000_0010, 32'h0000_0024, 32'hF800_0001, 32'h0, 1'b0, 0, 1'b1);
        issue(4'd9, 1'b1, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 1'b0, 0, 1'b1);

        // Signed divide -7 / 2: o_ready must stay low for exactly 32 cycles.
        issue(4'd10, 1'b1, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 32, 1'b1);
        n = 0;
        while (!o_ready && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("div_busy_cycles", n, 32);

        issue(4'd10, 1'b0, 32'h0000_1234, 32'h0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 0, 1'b1);
        issue(4'd10, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 32, 1'b1);
        issue(4'd13, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 32'h0, 1'b0, 0, 1'b1);

        // Flush in the accept cycle drops the request.
        i_valid = 1'b1;
        i_flush = 1'b1;
        i_op    = 4'd7;
        i_src_a = 32'd1;
        i_src_b = 32'd1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_flush = 1'b0;
        chk("flush_accept_valid", o_valid, 0);
        chk("flush_accept_ready", o_ready, 1);

        // Flush at cycle 10 of an unsigned divide.
        issue(4'd10, 1'b0, 32'h0012_3456, 32'h0000_0033, '0, '0, 1'b0, 0, 1'b0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        chk("flush_busy", o_ready, 0);
        i_flush = 1'b1;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        chk("flush_idle", o_ready, 1);
        repeat (40) @(posedge clk);
        #1;
        issue(4'd7, 1'b0, 32'd5, 32'd7, 32'd12, 32'd0, 1'b0, 0, 1'b1);
        repeat (2) @(posedge clk);
        #1;

        // Reset during DIV_RUN with an ADD presented in the same cycle.
        issue(4'd10, 1'b1, 32'h0000_0100, 32'h0000_0003, '0, '0, 1'b0, 0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        i_rst_n = 1'b0;
        i_valid = 1'b1;
        i_op    = 4'd7;
        i_src_a = 32'd5;
        i_src_b = 32'd7;
        @(posedge clk);
        #1;
        i_rst_n = 1'b1;
        i_valid = 1'b0;
        chk("rst_mid_valid", o_valid, 0);
        chk("rst_mid_lo", o_lo, 0);
        chk("rst_mid_hi", o_hi, 0);
        chk("rst_mid_div_zero", o_div_zero, 0);
        chk("rst_mid_ready", o_ready, 1);
        repeat (40) @(posedge clk);
        #1;

        // Randomized traffic, mostly back-to-back.
        for (int i = 0; i < 300; i++) begin
            logic [3:0]   op;
            logic [W-1:0] a, b;
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) op = 4'd10;
            a = pick_operand();
            b = pick_operand();
            if (op == 4'd10 && $urandom_range(0, 3) != 0) b = b >> $urandom_range(0, 28);
            issue_rand(op, 1'($urandom_range(0, 1)), a, b);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("sb_drain", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width; legal values 8..64, power of two.
REQ-002 Parameter SHAMT_W, default $clog2(DATA_W), shift-amount width; derived, never overridden.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 i_valid  input  1  operation request.
REQ-006 i_op  input  4  opcode: 0 OR, 1 AND, 2 NOR, 3 XOR, 4 SLL, 5 SRL, 6 SRA, 7 ADD, 8 SUB, 9 MUL, 10 DIV, 11-15 illegal.
REQ-007 i_signed  input  1  signed interpretation for MUL/DIV; ignored for other ops.
REQ-008 i_src_a  input  DATA_W  operand A (shift data, dividend, minuend).
REQ-009 i_src_b  input  DATA_W  operand B (shift amount, divisor, subtrahend).
REQ-010 i_flush  input  1  pipeline flush; aborts an in-flight divide.
REQ-011 o_ready  output  1  block can accept a request this cycle.
REQ-012 o_valid  output  1  result valid, one-cycle pulse.
REQ-013 o_lo  output  DATA_W  primary result / MUL low half / DIV quotient.
REQ-014 o_hi  output  DATA_W  MUL high half / DIV remainder; 0 for all other ops.
REQ-015 o_div_zero  output  1  qualifies o_valid: divide by zero occurred.

Function
REQ-016 States IDLE, DIV_RUN; o_ready = 1 only in IDLE.
REQ-017 Request accepted when i_valid & o_ready & ~i_flush; i_flush in the accept cycle drops the request, no o_valid.
REQ-018 Non-DIV ops: registered result, o_valid exactly 1 cycle after accept, state stays IDLE; back-to-back accepts every cycle permitted.
REQ-019 Logic ops: bitwise A|B, A&B, ~(A|B), A^B.
REQ-020 Shifts: A shifted by B[SHAMT_W-1:0]; SLL/SRL zero-fill, SRA replicates A[DATA_W-1]; upper B bits ignored.
REQ-021 ADD/SUB: A+B, A-B modulo 2^DATA_W, no overflow flag.
REQ-022 MUL: full 2*DATA_W product, unsigned or two's-complement per i_signed; {o_hi,o_lo} = product.
REQ-023 DIV, B != 0: IDLE -> DIV_RUN, radix-2 restoring iteration on magnitudes, one quotient bit per cycle, DATA_W cycles; o_valid in cycle DATA_W+1 after accept, state returns to IDLE same cycle (o_ready high).
REQ-024 Signed DIV: quotient truncates toward zero, remainder takes dividend's sign; MIN / -1 yields o_lo = MIN, o_hi = 0.
REQ-025 DIV, B == 0: no iteration; o_valid 1 cycle after accept, o_div_zero = 1, o_lo = all ones, o_hi = A.
REQ-026 i_flush in DIV_RUN: return to IDLE next edge, no o_valid for that divide, iteration registers discarded.
REQ-027 i_valid while o_ready = 0 is ignored; requester holds request until accepted.
REQ-028 Illegal opcode: o_valid 1 cycle after accept with o_lo = o_hi = 0, o_div_zero = 0.
REQ-029 o_lo/o_hi/o_div_zero hold last value when o_valid = 0; only sampled with o_valid.

Reset
REQ-030 i_rst_n = 0 at a rising edge: state IDLE, o_valid = 0, o_lo = o_hi = 0, o_div_zero = 0, divider registers cleared; o_ready = 1 from the next cycle.
REQ-031 Reset mid-divide aborts it, no o_valid after reset release.

Verification (DATA_W = 32)
REQ-032 SRA A=0x80000010, B=0x24 -> shift 4, o_lo=0xF8000001, o_valid 1 cycle later.
REQ-033 Signed MUL A=0xFFFFFFFE (-2), B=3 -> o_hi=0xFFFFFFFF, o_lo=0xFFFFFFFA.
REQ-034 Signed DIV A=-7, B=2 -> o_ready low 32 cycles, o_valid cycle 33, o_lo=0xFFFFFFFD, o_hi=0xFFFFFFFF.
REQ-035 DIV A=0x1234, B=0 -> o_valid next cycle, o_div_zero=1, o_lo=0xFFFFFFFF, o_hi=0x1234.
REQ-036 Unsigned DIV accepted, i_flush at cycle 10 -> IDLE cycle 11, no o_valid; following ADD 5+7 -> o_lo=12.
REQ-037 i_rst_n low during DIV_RUN, ADD issued same cycle -> no o_valid, outputs 0, o_ready=1 after release.
